sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised single-clock FIFO: next generation of the team's producer/consumer buffer, generalised in width and depth, with all `DEPTH` entries usable, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and optional sticky error flags. It sits between a producer and a consumer that share one clock. It is the standard elastic buffer for same-clock datapaths in the design.

## Interface
- `WIDTH`, 16: data word width in bits, ≥1.
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `ALMOST_FULL_TH`, 6: `almost_full` asserted when count ≥ this; range 1..DEPTH.
- `ALMOST_EMPTY_TH`, 1: `almost_empty` asserted when count ≤ this; range 0..DEPTH-1.
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `flush` in 1: synchronous clear of contents, active-high.
- `data_1_en` in 1: write request.
- `data_1` in WIDTH: write data.
- `data_2_rd` in 1: read request.
- `data_2` out WIDTH: read data, registered.
- `data_2_valid` out 1: `data_2` holds a newly popped word this cycle.
- `buffer_full` out 1: count == DEPTH.
- `buffer_empty` out 1: count == 0.
- `almost_full` / `almost_empty` out 1: threshold flags.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` / `underflow` out 1: sticky error flags (only with `SYNC_FIFO_ERR_FLAGS_EN`).

## Operation
- Write accepted iff `data_1_en && !buffer_full`: word stored at write pointer, pointer +1 mod DEPTH.
- Read accepted iff `data_2_rd && !buffer_empty`: word at read pointer loaded into `data_2`, `data_2_valid`=1 next cycle, pointer +1 mod DEPTH.
- Cycle without accepted read: `data_2_valid`=0, `data_2` holds its last value.
- Pointers are $clog2(DEPTH)+1 bits: equal pointers mean empty, equal except MSB means full. All DEPTH entries are usable.
- `count` is updated in the same cycle as the pointers: +1 on write only, −1 on read only, unchanged on both or neither.
- Full with simultaneous write and read: write rejected, read accepted. Flags use the pre-edge state.
- Empty with simultaneous write and read: write accepted, read rejected. There is no bypass, so `data_2_valid`=0.
- `flush`=1: pointers and count go to 0 and `data_2_valid`=0. `data_2` is held. Flush overrides any write or read in the same cycle. Error flags are not cleared.
- `reset` low: same as flush, plus `data_2`=0 and error flags cleared. Reset has priority over flush.
- Storage array is not reset.

## Timing
- Reset values: `data_2`=0, `data_2_valid`=0, `count`=0, `buffer_empty`=1, `buffer_full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0.
- Read latency: 1 cycle from accepted `data_2_rd` to `data_2_valid`.
- Write-to-readable latency: a word written at edge N can be popped by a read request presented before edge N+1. It appears on `data_2` after edge N+1.
- Status flags are combinational decodes of registered pointers and count. They change only after the clock edge that caused the change.
- Back-to-back reads: when the FIFO is not empty, a read is accepted every cycle, giving one word per cycle.

## Configuration
- `SYNC_FIFO_ERR_FLAGS_EN` defined:
  - `overflow` sets on `data_1_en && buffer_full`.
  - `underflow` sets on `data_2_rd && buffer_empty`.
  - Both flags are sticky until reset.
- `SYNC_FIFO_ERR_FLAGS_EN` undefined: both ports and their logic are absent. Rejected requests are silently dropped.

## Structure
- Package `sync_fifo_pkg`:
  - default WIDTH/DEPTH constants;
  - pointer-width and count-width helper functions based on $clog2;
  - parameter-legality checks (power-of-two DEPTH, threshold ranges).
- Sub-module `sync_fifo_mem`: DEPTH×WIDTH array with 1 write port and 1 synchronous read port, no reset.
- Top level holds pointers, count, flags and the output register.

## Test plan
- Reset, then idle:
  - `buffer_empty`=1, `count`=0, `almost_empty`=1, `data_2`=0, `data_2_valid`=0.
  - A read while empty leaves pointers unchanged; `underflow`=1 if enabled.
- Write 0x0001..0x0008 (DEPTH=8):
  - `buffer_full`=1 and `count`=8 after the 8th edge; `almost_full`=1 from `count`=6.
  - A 9th write, 0x0009, is dropped; `overflow`=1 if enabled.
- Drain 8 reads back-to-back:
  - `data_2` = 0x0001..0x0008 on consecutive cycles with `data_2_valid`=1.
  - `buffer_empty`=1 afterwards.
- Fill 8, then one cycle of simultaneous write 0xAAAA and read:
  - 0x0001 is popped, 0xAAAA is rejected, `count`=7.
- Simultaneous write 0x1234 and read when empty:
  - `count`=1 and `data_2_valid`=0.
  - The next read returns 0x1234.
- Write 5 words, then `flush` together with a write and a read:
  - `count`=0, `buffer_empty`=1, `data_2_valid`=0.
  - Pointer wrap exercised by 20 further write/read pairs with data matching in order.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
// Pointer/count widths and parameter legality live here so top and interface agree.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // One extra pointer bit distinguishes full from empty when the address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int af_th, input int ae_th);
    return (width >= 1) && is_pow2(depth) &&
           (af_th >= 1) && (af_th <= depth) &&
           (ae_th >= 0) && (ae_th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle of sync_fifo_param; sticky error flags exist only
// when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = cnt_w(DEPTH);

  // Handshake: a write is taken on the edge where data_1_en && !buffer_full,
  // a read on the edge where data_2_rd && !buffer_empty; the popped word shows
  // on data_2 with data_2_valid for the one following cycle. Rejected requests drop.
  logic             flush;
  logic             data_1_en;
  logic [WIDTH-1:0] data_1;
  logic             data_2_rd;
  logic [WIDTH-1:0] data_2;
  logic             data_2_valid;
  logic             buffer_full;
  logic             buffer_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, data_1_en, data_1, data_2_rd,
    input  data_2, data_2_valid, buffer_full, buffer_empty,
           almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  flush, data_1_en, data_1, data_2_rd,
    output data_2, data_2_valid, buffer_full, buffer_empty,
           almost_full, almost_empty, count, overflow, underflow
  );
`else
  modport master (
    output flush, data_1_en, data_1, data_2_rd,
    input  data_2, data_2_valid, buffer_full, buffer_empty,
           almost_full, almost_empty, count
  );
  modport slave (
    input  flush, data_1_en, data_1, data_2_rd,
    output data_2, data_2_valid, buffer_full, buffer_empty,
           almost_full, almost_empty, count
  );
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: one write port, one registered read port, never reset.
module sync_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rd_data holds between reads, which gives the FIFO its data-hold behaviour.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data      <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and flush.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input logic             clock,
  input logic             reset,
  sync_fifo_param_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

  if (!params_ok(WIDTH, DEPTH, ALMOST_FULL_TH, ALMOST_EMPTY_TH)) begin : g_bad_params
    $error("sync_fifo_param: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             valid_q;
  logic             loaded_q;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rd_data;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = ((wr_ptr ^ rd_ptr) == FULL_XOR);
  assign wr_acc = bus.data_1_en && !full  && !bus.flush;
  assign rd_acc = bus.data_2_rd && !empty && !bus.flush;

  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clock   (clock),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (bus.data_1),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  // loaded_q masks the unreset storage read register until the first pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) loaded_q <= 1'b1;
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    bus.data_2       = loaded_q ? mem_rd_data : '0;
    bus.data_2_valid = valid_q;
    bus.buffer_full  = full;
    bus.buffer_empty = empty;
    bus.almost_full  = (count_q >= CW'(ALMOST_FULL_TH));
    bus.almost_empty = (count_q <= CW'(ALMOST_EMPTY_TH));
    bus.count        = count_q;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  // Sticky until reset; flush deliberately leaves them alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.data_1_en && full)  ovf_q <= 1'b1;
      if (bus.data_2_rd && empty) unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule
